// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake, bit-serial shifts and an
// optional iterative shift-add multiplier enabled by SEQ_ALU_MUL_EN.
module seq_alu #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CTRL_W-1:0]        alu_ctrl,
  input  logic [WIDTH-1:0]         op1,
  input  logic [WIDTH-1:0]         op2,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     zero_flag,
  output logic                     ovf,
  output logic                     err
);
  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1010);
`ifdef SEQ_ALU_MUL_EN
  localparam logic [1:0]        S_MUL   = 2'd2;
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b1100);
`endif

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d, err_q, err_d, done_q, done_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CTRL_W-1:0] op_q, op_d;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0]  acc_q, acc_d, mplier_q, mplier_d, acc_next;
`endif

  logic [WIDTH-1:0] sum, diff, shl, shifted;
  logic             fill, ovf_add, ovf_sub, accept;

  assign sum     = op1 + op2;
  assign diff    = op1 - op2;
  assign ovf_add = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
  assign ovf_sub = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
  assign shl     = {work_q[WIDTH-2:0], 1'b0};
  assign fill    = (op_q == OP_SRA) && work_q[WIDTH-1];
  assign shifted = (op_q == OP_SLL) ? shl : {fill, work_q[WIDTH-1:1]};
  // DONE accepts a new request just like IDLE, giving back-to-back issue.
  assign accept  = start && (state_q == S_IDLE || state_q == S_DONE);
`ifdef SEQ_ALU_MUL_EN
  assign acc_next = acc_q + (mplier_q[0] ? work_q : '0);
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
`ifdef SEQ_ALU_MUL_EN
    acc_d    = acc_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      S_SHIFT: begin
        work_d  = shifted;
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          result_d = shifted;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      S_MUL: begin
        acc_d    = acc_next;
        work_d   = shl;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          result_d = acc_next;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if ((alu_ctrl == OP_SLL || alu_ctrl == OP_SRL || alu_ctrl == OP_SRA) && shamt != '0) begin
            work_d  = op2;
            count_d = {1'b0, shamt};
            op_d    = alu_ctrl;
            state_d = S_SHIFT;
`ifdef SEQ_ALU_MUL_EN
          end else if (alu_ctrl == OP_MUL) begin
            work_d   = op1;
            mplier_d = op2;
            acc_d    = '0;
            count_d  = CNT_W'(WIDTH);
            state_d  = S_MUL;
`endif
          end else begin
            done_d = 1'b1;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
            case (alu_ctrl)
              OP_AND:  result_d = op1 & op2;
              OP_OR:   result_d = op1 | op2;
              OP_XOR:  result_d = op1 ^ op2;
              OP_NOR:  result_d = ~(op1 | op2);
              OP_ADD:  begin result_d = sum;  ovf_d = ovf_add; end
              OP_SUB:  begin result_d = diff; ovf_d = ovf_sub; end
              OP_SLT:  result_d = WIDTH'($signed(op1) < $signed(op2));
              OP_SLTU: result_d = WIDTH'(op1 < op2);
              OP_SLL, OP_SRL, OP_SRA: result_d = op2;  // zero-amount shift
              default: begin result_d = '0; err_d = 1'b1; end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
`ifdef SEQ_ALU_MUL_EN
      acc_q    <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
`ifdef SEQ_ALU_MUL_EN
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
`endif
    end
  end

`ifdef SEQ_ALU_MUL_EN
  assign busy = (state_q == S_SHIFT) || (state_q == S_MUL);
`else
  assign busy = (state_q == S_SHIFT);
`endif
  assign done      = done_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign zero_flag = (result_q == '0);
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the datapath ALU of the multi-cycle MIPS core.
- Adds a start/busy/done handshake, a signed-overflow flag and an illegal-op flag.
- Adds variable-amount shifts (one bit per cycle) and an optional iterative shift-add multiplier.
- Sits between the register-file operand latches and the ALUOut register. The control FSM issues `start` and waits on `done`.

Parameters:
- WIDTH, 32: operand and result width in bits; must be a power of two, 8 or more.
- CTRL_W, 4: width of the `alu_ctrl` opcode field.
- Derived, not overridable: SHW = $clog2(WIDTH).

Ports:
- clk  input  1  clock; all flops update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- alu_ctrl  input  CTRL_W  opcode; sampled on acceptance.
- op1  input  WIDTH  operand A; sampled on acceptance.
- op2  input  WIDTH  operand B (also the shift source); sampled on acceptance.
- shamt  input  SHW  shift amount; sampled on acceptance.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  registered result; held until the next acceptance.
- zero_flag  output  1  combinational: result == 0.
- ovf  output  1  signed overflow of add/sub; 0 for all other ops.
- err  output  1  illegal opcode; registered with done.

Behaviour:
- Reset (rst_n=0, async): busy=0, done=0, result=0, ovf=0, err=0, FSM=IDLE. zero_flag is therefore 1.
  - Reset during SHIFT or MUL aborts the operation; no done pulse follows.
- Acceptance: at the rising edge E0 where start=1 and busy=0, the block captures alu_ctrl, op1, op2 and shamt.
  - start while busy=1 is ignored and not queued.
- Opcodes:
  - 0000 and
  - 0001 or
  - 0010 add
  - 0110 sub
  - 0111 slt (signed)
  - 0011 sll
  - 0100 srl
  - 0101 sra
  - 1000 sltu
  - 1001 xor
  - 1010 nor
  - 1100 mul (low WIDTH bits of the product)
  - Any other code is illegal.
- Single-cycle ops (logic, add, sub, slt, sltu) and illegal codes:
  - result, ovf and err are registered at E0; done=1 in the cycle after E0; busy is never asserted.
  - An illegal code gives result=0 and err=1.
- Add/sub:
  - Wrap modulo 2^WIDTH.
  - ovf = operand signs equal (after negating op2 for sub) and result sign differs.
- slt/sltu: result = 1 or 0, zero-extended to WIDTH.
- Shifts:
  - shamt=0 behaves as a single-cycle op: result=op2, done after E0.
  - Otherwise the FSM enters SHIFT with count=shamt and busy=1.
  - Each edge shifts the working register by one bit and decrements count.
  - Fill: sll/srl fill with 0; sra fills with op2[WIDTH-1].
  - done after edge E0+shamt.
- Multiply (when compiled in):
  - FSM enters MUL with busy=1.
  - Each edge examines one multiplier bit, LSB first; if the bit is 1, the shifted multiplicand is added to the accumulator.
  - Exactly WIDTH iterations; done after edge E0+WIDTH. No early termination.
  - Signed and unsigned give identical low bits.
- FSM states and transitions:
  - IDLE goes to SHIFT or MUL on acceptance, otherwise stays in IDLE (single-cycle ops complete at E0).
  - SHIFT goes to DONE when count reaches 0; MUL goes to DONE after WIDTH iterations.
  - DONE goes to IDLE after one cycle. In DONE, done=1 and busy=0.
- Back-to-back: a start presented in the done cycle is accepted at that edge.
- Result hold: result and flags are held until the next acceptance.
  - During SHIFT/MUL, result keeps its previous value; the working register is internal.
- Simultaneous events: rst_n low overrides start.

Optional Feature:
- Macro SEQ_ALU_MUL_EN.
- Defined: opcode 1100 is implemented as the iterative multiplier above, and the MUL state exists.
- Undefined: 1100 is treated as an illegal opcode (single-cycle, result=0, err=1). No multiplier datapath or MUL state is synthesised.

Test Plan (WIDTH=32):
- Reset, then add 0x7FFFFFFF+0x00000001 → done at the cycle after E0, result=0x80000000, ovf=1, zero_flag=0. Then sub 5-5 → result=0, zero_flag=1, ovf=0.
- slt 0xFFFFFFFF vs 0x00000001 → result=1. sltu on the same operands → result=0. Opcode 1111 → result=0, err=1.
- sra op2=0x80000000, shamt=4 → busy high for 4 cycles, done after E0+4, result=0xF8000000. sll by 0 → result=op2, done after E0.
- mul 0xFFFFFFFD × 7 (MUL_EN defined) → done after E0+32, result=0xFFFFFFEB. With the macro undefined, the same request gives err=1 at E0+1.
- start pulsed mid-SHIFT with different operands → ignored, original result unchanged. New start in the done cycle → accepted, no idle gap.
- rst_n dropped mid-MUL → busy=0 and result=0 immediately; no done pulse follows.
